// File: rtl/dma_req_arbiter_if.sv
// dma_req_arbiter_if: per-requester request/completion handshakes plus the shared DMA channel
interface dma_req_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int REQ_BITS = 96
);
  logic [N_REQ-1:0]          s_valid;
  logic [N_REQ-1:0]          s_ready;
  logic [N_REQ-1:0]          s_done;
  logic [N_REQ*REQ_BITS-1:0] s_req;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_done;
  logic [REQ_BITS-1:0]       m_req;
  modport master (output s_valid, s_req, m_ready, m_done, input s_ready, s_done, m_valid, m_req);
  modport slave  (input s_valid, s_req, m_ready, m_done, output s_ready, s_done, m_valid, m_req);
endinterface

// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter: round-robin DMA request arbiter with in-order completion routing and drain/decouple FSM
// Optional per-requester grant counters on output grant_cnt when DMA_ARB_STATS_EN is defined.
module dma_req_arbiter #(
  parameter int N_REQ     = 4,
  parameter int REQ_BITS  = 96,
  parameter int MAX_OUTST = 16
) (
  input  logic             aclk,
  input  logic             areset,
  dma_req_arbiter_if.slave bus,
  input  logic             decouple_req,
  output logic             decoupled,
  output logic             err_spurious
`ifdef DMA_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0] grant_cnt
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {RUN, DRAIN, DCPL} state_t;
  state_t              state_q, state_d;
  logic                out_vld_q, out_vld_d;
  logic [REQ_BITS-1:0] out_req_q;
  logic [IW-1:0]       out_id_q, last_q, win_id, j;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wr_q, rd_q;
  logic [IW-1:0]       fifo_q [MAX_OUTST];
  logic                err_q, dcpl_q, win_found, accept, hs, pop;
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    j         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IW'((int'(last_q) + 1 + k) % N_REQ);
      if (!win_found && bus.s_valid[j]) begin
        win_found = 1'b1;
        win_id    = j;
      end
    end
  end
  // occupancy of the output register counts toward the outstanding limit
  assign accept = win_found && state_q == RUN && !areset && (!out_vld_q || bus.m_ready) &&
                  (32'(cnt_q) + 32'(out_vld_q) < 32'(MAX_OUTST));
  assign hs        = out_vld_q && bus.m_ready;
  assign pop       = bus.m_done && cnt_q != '0 && state_q != DCPL && !areset;
  assign cnt_d     = cnt_q + CW'(hs) - CW'(pop);
  assign out_vld_d = accept || (out_vld_q && !bus.m_ready);
  assign state_d   = state_q == RUN ? (decouple_req ? DRAIN : RUN) :
                     !decouple_req ? RUN :
                     (state_q == DRAIN && !out_vld_d && cnt_d == '0) ? DCPL : state_q;
  assign bus.s_ready  = accept ? N_REQ'(1) << win_id : '0;
  assign bus.s_done   = pop ? N_REQ'(1) << fifo_q[rd_q] : '0;
  assign bus.m_valid  = out_vld_q && !areset;
  assign bus.m_req    = areset ? '0 : out_req_q;
  assign decoupled    = dcpl_q && !areset;
  assign err_spurious = err_q && !areset;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= RUN;
      out_vld_q <= 1'b0;
      out_req_q <= '0;
      out_id_q  <= '0;
      last_q    <= IW'(N_REQ - 1);
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      dcpl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcpl_q    <= state_d == DCPL;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        out_req_q <= bus.s_req[win_id*REQ_BITS +: REQ_BITS];
        out_id_q  <= win_id;
        last_q    <= win_id;
      end
      if (hs) begin
        fifo_q[wr_q] <= out_id_q;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (bus.m_done && !pop) err_q <= 1'b1;
    end
  end
`ifdef DMA_ARB_STATS_EN
  logic [N_REQ*32-1:0] grant_cnt_q;
  always_ff @(posedge aclk) begin
    if (areset) grant_cnt_q <= '0;
    else if (hs) grant_cnt_q[out_id_q*32 +: 32] <= grant_cnt_q[out_id_q*32 +: 32] + 32'd1;
  end
  assign grant_cnt = grant_cnt_q;
`endif
endmodule

// File: tb/tb_dma_req_arbiter.sv
// tb_dma_req_arbiter: table-driven directed check of arbitration, back-pressure, limits, drain and reset
module tb_dma_req_arbiter;
  localparam int N = 4;
  localparam int RB = 16;
  logic clk, areset, decouple_req, decoupled, err_spurious;
  int checks = 0, failures = 0;
  dma_req_arbiter_if #(.N_REQ(N), .REQ_BITS(RB)) bus ();
`ifdef DMA_ARB_STATS_EN
  logic [N*32-1:0] grant_cnt;
`endif
  dma_req_arbiter #(.N_REQ(N), .REQ_BITS(RB), .MAX_OUTST(4)) dut (
    .aclk(clk), .areset(areset), .bus(bus.slave), .decouple_req(decouple_req),
    .decoupled(decoupled), .err_spurious(err_spurious)
`ifdef DMA_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic rst; logic [3:0] v; logic mr, md, dec;
    logic [3:0] e_rdy, e_done; logic e_mv; int e_id; logic e_dc, e_err;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic mr, md, dec,
                              input logic [3:0] rdy, dn, input logic mv, input int id,
                              input logic dc, er);
    vec_t t;
    t.rst = rst; t.v = v; t.mr = mr; t.md = md; t.dec = dec;
    t.e_rdy = rdy; t.e_done = dn; t.e_mv = mv; t.e_id = id; t.e_dc = dc; t.e_err = er;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic rst, input logic [3:0] v, input logic mr, md, dec);
    @(posedge clk);
    #1;
    areset = rst; bus.s_valid = v; bus.m_ready = mr; bus.m_done = md; decouple_req = dec;
    @(negedge clk);
  endtask
  task automatic chk_all(input string tag, input vec_t t);
    chk({tag, ".s_ready"}, 32'(bus.s_ready), 32'(t.e_rdy));
    chk({tag, ".s_done"}, 32'(bus.s_done), 32'(t.e_done));
    chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(t.e_mv));
    if (t.e_mv) chk({tag, ".m_req"}, 32'(bus.m_req), 32'(16'hA000 + t.e_id));
    chk({tag, ".decoupled"}, 32'(decoupled), 32'(t.e_dc));
    chk({tag, ".err"}, 32'(err_spurious), 32'(t.e_err));
  endtask
  initial begin
    areset = 1'b1; decouple_req = 1'b0;
    bus.s_valid = '0; bus.m_ready = 1'b0; bus.m_done = 1'b0;
    bus.s_req = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    // reset with busy inputs
    tbl.push_back(mk(1, 4'hF, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // round robin 0,1,2,3,0 with continuous m_valid
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 0, 4, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 0, 8, 2, 1, 2, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 0, 1, 4, 1, 3, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    // back-pressure hold
    tbl.push_back(mk(0, 4'h6, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'h6, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h6, 1, 0, 0, 4, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1, 2, 0, 0));
    // drain with 2 outstanding, decouple, spurious done, resume
    tbl.push_back(mk(0, 4'h0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 1, 0, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 8, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1, 3, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 8, 0, 0, 0, 1));
    // outstanding limit of 4, then push+pop at count 3
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 4, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 8, 0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 0, 0, 1, 3, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 2, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    // mid-operation reset, spurious done at count 0, restart
    tbl.push_back(mk(0, 4'h4, 0, 0, 0, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].mr, tbl[i].md, tbl[i].dec);
      chk_all($sformatf("v%0d", i), tbl[i]);
    end
    // drain abandoned when decouple_req falls before the outstanding request completes
    cyc(0, 4'h0, 1, 0, 1);
    chk("abort.dc0", 32'(decoupled), 0);
    cyc(0, 4'hF, 1, 0, 1);
    chk("abort.blocked1", 32'(bus.s_ready), 0);
    cyc(0, 4'hF, 1, 0, 0);
    chk("abort.blocked2", 32'(bus.s_ready), 0);
    cyc(0, 4'hF, 1, 0, 0);
    chk("abort.resume", 32'(bus.s_ready), 32'h2);
    chk("abort.dc1", 32'(decoupled), 0);
    cyc(0, 4'h0, 1, 1, 0);
    chk("abort.m_req", 32'(bus.m_req), 32'hA001);
    chk("abort.s_done", 32'(bus.s_done), 32'h1);
    cyc(0, 4'h0, 1, 0, 0);
    chk("abort.idle", 32'(bus.m_valid), 0);
`ifdef DMA_ARB_STATS_EN
    chk("stats.g0", grant_cnt[31:0], 1);
    chk("stats.g1", grant_cnt[63:32], 1);
    chk("stats.g2", grant_cnt[95:64], 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
